// File: rtl/uart_rx_param_if.sv
// Bus bundle for the parametrised UART receiver: baud tick, serial line,
// read acknowledge in; received word and status out.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 sTick;
  logic                 rx;
  logic                 rdAck;
  logic [DATA_BITS-1:0] dOut;
  logic                 dValid;
  logic                 rxDoneTick;
  logic                 parityErr;
  logic                 frameErr;
  logic                 overrun;

  // Core / baud-generator side
  modport master (
    output sTick, rx, rdAck,
    input  dOut, dValid, rxDoneTick, parityErr, frameErr, overrun
  );

  // Receiver side
  modport slave (
    input  sTick, rx, rdAck,
    output dOut, dValid, rxDoneTick, parityErr, frameErr, overrun
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with synchroniser, false-start
// rejection, parity/framing/overrun flags and a valid/ack holding register.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input logic            clk,
  input logic            reset,
  uart_rx_param_if.slave bus
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_END  = BIT_W'(DATA_BITS - 1);
  localparam logic             STOP_END = 1'(STOP_BITS - 1);
  localparam logic             ODD      = (PARITY_ODD != 0);
  localparam logic             PAR_ON   = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [1:0]           r_sync;
  logic                 r_prev;
  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [BIT_W-1:0]     r_bit, w_bit_nxt;
  logic                 r_stop, w_stop_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_par, w_par_nxt;
  logic                 r_perr_pend, w_perr_nxt;
  logic                 r_ferr_pend, w_ferr_nxt;
  logic                 w_deliver;

  logic [DATA_BITS-1:0] r_dout;
  logic                 r_dvalid;
  logic                 r_done;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_ovr;

  logic w_rx;
  logic w_fall;

  assign w_rx   = r_sync[1];
  assign w_fall = r_prev & ~w_rx;

  // Two-flop synchroniser on rx plus previous-value register for edge detect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], bus.rx};
      r_prev <= w_rx;
    end
  end

  // Receive FSM: next state, counters, shift register and pending error flags
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_stop_nxt  = r_stop;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_perr_nxt  = r_perr_pend;
    w_ferr_nxt  = r_ferr_pend;
    w_deliver   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
        end
      end
      S_START: begin
        if (bus.sTick) begin
          if (r_cnt == CNT_MID) begin
            w_cnt_nxt = '0;
            if (!w_rx) begin
              w_state_nxt = S_DATA;
              w_bit_nxt   = '0;
              w_par_nxt   = 1'b0;
              w_perr_nxt  = 1'b0;
              w_ferr_nxt  = 1'b0;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_DATA: begin
        if (bus.sTick) begin
          if (r_cnt == CNT_END) begin
            w_cnt_nxt   = '0;
            w_shift_nxt = {w_rx, r_shift[DATA_BITS-1:1]};
            w_par_nxt   = r_par ^ w_rx;
            if (r_bit == BIT_END) begin
              w_bit_nxt   = '0;
              w_stop_nxt  = 1'b0;
              w_state_nxt = PAR_ON ? S_PARITY : S_STOP;
            end else begin
              w_bit_nxt = r_bit + BIT_W'(1);
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (bus.sTick) begin
          if (r_cnt == CNT_END) begin
            w_cnt_nxt   = '0;
            w_stop_nxt  = 1'b0;
            w_perr_nxt  = ((r_par ^ w_rx) != ODD);
            w_state_nxt = S_STOP;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_STOP: begin
        if (bus.sTick) begin
          if (r_cnt == CNT_END) begin
            w_cnt_nxt = '0;
            if (!w_rx) begin
              w_ferr_nxt = 1'b1;
            end
            if (r_stop == STOP_END) begin
              w_stop_nxt  = 1'b0;
              w_state_nxt = S_IDLE;
              w_deliver   = 1'b1;
            end else begin
              w_stop_nxt = r_stop + 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // FSM state, counters and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_stop      <= 1'b0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_perr_pend <= 1'b0;
      r_ferr_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit       <= w_bit_nxt;
      r_stop      <= w_stop_nxt;
      r_shift     <= w_shift_nxt;
      r_par       <= w_par_nxt;
      r_perr_pend <= w_perr_nxt;
      r_ferr_pend <= w_ferr_nxt;
    end
  end

  // Holding register: delivery takes priority over a coincident rdAck
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dout   <= '0;
      r_dvalid <= 1'b0;
      r_done   <= 1'b0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
      r_ovr    <= 1'b0;
    end else if (w_deliver) begin
      r_dout   <= r_shift;
      r_dvalid <= 1'b1;
      r_done   <= 1'b1;
      r_perr   <= w_perr_nxt;
      r_ferr   <= w_ferr_nxt;
      if (r_dvalid && !bus.rdAck) begin
        r_ovr <= 1'b1;
      end
    end else begin
      r_done <= 1'b0;
      if (bus.rdAck && r_dvalid) begin
        r_dvalid <= 1'b0;
        r_ovr    <= 1'b0;
      end
    end
  end

  assign bus.dOut       = r_dout;
  assign bus.dValid     = r_dvalid;
  assign bus.rxDoneTick = r_done;
  assign bus.parityErr  = r_perr;
  assign bus.frameErr   = r_ferr;
  assign bus.overrun    = r_ovr;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three configurations (8N1, 8E1, 7N2)
// share clock, reset and baud tick; a per-instance queue holds the frames
// expected at each rxDoneTick.
module tb_uart_rx_param;

  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = 16 * TICK_DIV;

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int   n_vec = 0;
  int   n_err = 0;
  int   done_cnt [3] = '{0, 0, 0};
  exp_t q_def [$];
  exp_t q_par [$];
  exp_t q_s2  [$];

  uart_rx_param_if #(.DATA_BITS(8)) if_def ();
  uart_rx_param_if #(.DATA_BITS(8)) if_par ();
  uart_rx_param_if #(.DATA_BITS(7)) if_s2 ();

  uart_rx_param #(.DATA_BITS(8)) u_def (.clk(clk), .reset(reset), .bus(if_def));
  uart_rx_param #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0))
    u_par (.clk(clk), .reset(reset), .bus(if_par));
  uart_rx_param #(.DATA_BITS(7), .STOP_BITS(2))
    u_s2 (.clk(clk), .reset(reset), .bus(if_s2));

  always #5 clk = ~clk;

  // Baud tick: one clk pulse every TICK_DIV clocks, shared by all instances
  initial begin
    int ph;
    ph = 0;
    if_def.sTick = 1'b0;
    if_par.sTick = 1'b0;
    if_s2.sTick  = 1'b0;
    forever begin
      @(negedge clk);
      ph = (ph + 1) % TICK_DIV;
      if_def.sTick = (ph == 0);
      if_par.sTick = (ph == 0);
      if_s2.sTick  = (ph == 0);
    end
  end

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk9(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chki(input string tag, input int got, input int exp);
    n_vec++;
    assert (got == exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic sb_pop(input int sel, input logic [8:0] d, input logic pe, fe, dv);
    exp_t e;
    logic have;
    done_cnt[sel]++;
    case (sel)
      0:       have = (q_def.size() != 0);
      1:       have = (q_par.size() != 0);
      default: have = (q_s2.size() != 0);
    endcase
    chk1($sformatf("sb%0d_frame_expected", sel), have, 1'b1);
    if (have) begin
      case (sel)
        0:       e = q_def.pop_front();
        1:       e = q_par.pop_front();
        default: e = q_s2.pop_front();
      endcase
      chk9($sformatf("sb%0d_dOut", sel), d, e.d);
      chk1($sformatf("sb%0d_parityErr", sel), pe, e.pe);
      chk1($sformatf("sb%0d_frameErr", sel), fe, e.fe);
      chk1($sformatf("sb%0d_dValid", sel), dv, 1'b1);
    end
  endtask

  // Scoreboard monitor: every delivery pulse must match the oldest expected frame
  always @(negedge clk) begin
    if (if_def.rxDoneTick)
      sb_pop(0, {1'b0, if_def.dOut}, if_def.parityErr, if_def.frameErr, if_def.dValid);
    if (if_par.rxDoneTick)
      sb_pop(1, {1'b0, if_par.dOut}, if_par.parityErr, if_par.frameErr, if_par.dValid);
    if (if_s2.rxDoneTick)
      sb_pop(2, {2'b0, if_s2.dOut}, if_s2.parityErr, if_s2.frameErr, if_s2.dValid);
  end

  task automatic set_rx(input int sel, input logic b);
    case (sel)
      0:       if_def.rx = b;
      1:       if_par.rx = b;
      default: if_s2.rx  = b;
    endcase
  endtask

  task automatic drive_bit(input int sel, input logic b);
    set_rx(sel, b);
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic pulse_ack(input int sel);
    case (sel)
      0:       if_def.rdAck = 1'b1;
      1:       if_par.rdAck = 1'b1;
      default: if_s2.rdAck  = 1'b1;
    endcase
    @(negedge clk);
    if_def.rdAck = 1'b0;
    if_par.rdAck = 1'b0;
    if_s2.rdAck  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Sends one frame and queues the result the receiver must report for it
  task automatic send_frame(input int sel, input logic [8:0] d, input int nbits,
                            input logic par_en, input logic par_odd, input logic pbit,
                            input int nstop, input logic stop2);
    exp_t e;
    logic x;
    x = 1'b0;
    for (int i = 0; i < nbits; i++) x ^= d[i];
    e.d  = d;
    e.pe = par_en & ((x ^ pbit) != par_odd);
    e.fe = (nstop == 2) && !stop2;
    case (sel)
      0:       q_def.push_back(e);
      1:       q_par.push_back(e);
      default: q_s2.push_back(e);
    endcase
    drive_bit(sel, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(sel, d[i]);
    if (par_en) drive_bit(sel, pbit);
    drive_bit(sel, 1'b1);
    if (nstop == 2) drive_bit(sel, stop2);
  endtask

  task automatic chk_def_zero(input string tag);
    chk9({tag, "_dOut"}, {1'b0, if_def.dOut}, 9'h000);
    chk1({tag, "_dValid"}, if_def.dValid, 1'b0);
    chk1({tag, "_rxDoneTick"}, if_def.rxDoneTick, 1'b0);
    chk1({tag, "_parityErr"}, if_def.parityErr, 1'b0);
    chk1({tag, "_frameErr"}, if_def.frameErr, 1'b0);
    chk1({tag, "_overrun"}, if_def.overrun, 1'b0);
  endtask

  initial begin
    if_def.rx = 1'b1; if_par.rx = 1'b1; if_s2.rx = 1'b1;
    if_def.rdAck = 1'b0; if_par.rdAck = 1'b0; if_s2.rdAck = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_def_zero("reset");
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // 8N1 frame 0xA5
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    drive_bit(0, 1'b1);
    chki("a5_frames", done_cnt[0], 1);
    chk9("a5_dOut", {1'b0, if_def.dOut}, 9'h0A5);
    chk1("a5_dValid", if_def.dValid, 1'b1);
    chk1("a5_overrun", if_def.overrun, 1'b0);
    pulse_ack(0);
    chk1("a5_ack_dValid", if_def.dValid, 1'b0);
    chk9("a5_ack_dOut_hold", {1'b0, if_def.dOut}, 9'h0A5);

    // False start: 4 sTicks low, then a valid 0x3C
    set_rx(0, 1'b0);
    repeat (4 * TICK_DIV) @(negedge clk);
    set_rx(0, 1'b1);
    repeat (2 * BIT_CLKS) @(negedge clk);
    chki("false_start_frames", done_cnt[0], 1);
    send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    drive_bit(0, 1'b1);
    chki("3c_frames", done_cnt[0], 2);
    chk9("3c_dOut", {1'b0, if_def.dOut}, 9'h03C);
    pulse_ack(0);

    // Overrun: two frames without an acknowledge
    send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    drive_bit(0, 1'b1);
    chki("ovr_frames", done_cnt[0], 4);
    chk9("ovr_dOut", {1'b0, if_def.dOut}, 9'h022);
    chk1("ovr_overrun", if_def.overrun, 1'b1);
    chk1("ovr_dValid", if_def.dValid, 1'b1);
    pulse_ack(0);
    chk1("ovr_ack_dValid", if_def.dValid, 1'b0);
    chk1("ovr_ack_overrun", if_def.overrun, 1'b0);
    chk9("ovr_ack_dOut_hold", {1'b0, if_def.dOut}, 9'h022);

    // Even parity: 0x07 with parity bit 0 is wrong, with 1 is right
    send_frame(1, 9'h007, 8, 1'b1, 1'b0, 1'b0, 1, 1'b1);
    drive_bit(1, 1'b1);
    chki("par0_frames", done_cnt[1], 1);
    chk9("par0_dOut", {1'b0, if_par.dOut}, 9'h007);
    chk1("par0_parityErr", if_par.parityErr, 1'b1);
    pulse_ack(1);
    send_frame(1, 9'h007, 8, 1'b1, 1'b0, 1'b1, 1, 1'b1);
    drive_bit(1, 1'b1);
    chki("par1_frames", done_cnt[1], 2);
    chk1("par1_parityErr", if_par.parityErr, 1'b0);
    pulse_ack(1);

    // 7 data bits, 2 stop bits, second stop bit low, line held low afterwards
    send_frame(2, 9'h055, 7, 1'b0, 1'b0, 1'b0, 2, 1'b0);
    repeat (3 * BIT_CLKS) @(negedge clk);
    chki("s2_frames", done_cnt[2], 1);
    chk9("s2_dOut", {2'b0, if_s2.dOut}, 9'h055);
    chk1("s2_frameErr", if_s2.frameErr, 1'b1);
    set_rx(2, 1'b1);
    repeat (2 * BIT_CLKS) @(negedge clk);
    chki("s2_no_retrigger", done_cnt[2], 1);

    // Reset during data bit 3, then a clean 0x81
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    set_rx(0, 1'b1);
    repeat (BIT_CLKS / 2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk_def_zero("midreset");
    @(negedge clk);
    reset = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    chki("midreset_frames", done_cnt[0], 4);
    send_frame(0, 9'h081, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    drive_bit(0, 1'b1);
    chki("81_frames", done_cnt[0], 5);
    chk9("81_dOut", {1'b0, if_def.dOut}, 9'h081);

    chk1("q_def_drained", (q_def.size() == 0), 1'b1);
    chk1("q_par_drained", (q_par.size() == 0), 1'b1);
    chk1("q_s2_drained", (q_s2.size() == 0), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
